// File: rtl/fetch_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// Entry layout is common to the storage array and the Decode register.
package fetch_pkg;

    localparam int FQ_WIDTH = 32;

    localparam logic [FQ_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [FQ_WIDTH-1:0] instr;
        logic [FQ_WIDTH-1:0] pcplus4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode-side handshake and status bundle for the fetch queue.
// master drives fetch words and decode control; slave is the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]               instrF;
    logic [WIDTH-1:0]               pcplus4F;
    logic                           validF;
    logic                           readyF;
    logic                           stallD;
    logic                           flushQ;
    logic [WIDTH-1:0]               instrD;
    logic [WIDTH-1:0]               pcplus4D;
    logic                           validD;
    logic [$clog2(DEPTH+1)-1:0]     countQ;

    modport master (
        output instrF, pcplus4F, validF, stallD, flushQ,
        input  readyF, instrD, pcplus4D, validD, countQ
    );

    modport slave (
        input  instrF, pcplus4F, validF, stallD, flushQ,
        output readyF, instrD, pcplus4D, validD, countQ
    );

endinterface

// File: rtl/fq_ctrl.sv
// Pointer/occupancy control for fetch_queue: push, pop, bypass and flush decisions.
// Zero-latency decisions from registered count; readyF drops only when full, never on stallD.
module fq_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          validF,
    input  logic          stallD,
    input  logic          flushQ,
    output logic          readyF,
    output logic [CW-1:0] countQ,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic          wr_en,
    output logic          pop,
    output logic          bypass,
    output logic          d_load
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_acc;
    logic          advance;

    // A push is refused while full even if a pop frees a slot the same cycle.
    always_comb begin
        full     = (count == DEPTH_C);
        empty    = (count == '0);
        readyF   = ~full;
        push_acc = validF & ~full & ~flushQ;
        advance  = ~stallD & ~flushQ;
        pop      = advance & ~empty;
        bypass   = advance & empty & push_acc;
        wr_en    = push_acc & ~bypass;
        d_load   = advance;
    end

    assign countQ = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flushQ) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue feeding the Decode register; 1-cycle push-to-instrD when empty.
// Absorbs decode stalls up to DEPTH words; readyF low only when full; flushQ empties everything.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FQ_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t     mem [DEPTH];
    fq_entry_t     in_e;
    fq_entry_t     d_q;
    logic          d_vld;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          pop;
    logic          bypass;
    logic          d_load;

    fq_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .validF (fq.validF),
        .stallD (fq.stallD),
        .flushQ (fq.flushQ),
        .readyF (fq.readyF),
        .countQ (fq.countQ),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .wr_en  (wr_en),
        .pop    (pop),
        .bypass (bypass),
        .d_load (d_load)
    );

    assign in_e = '{instr: fq.instrF, pcplus4: fq.pcplus4F};

    // Storage carries no reset; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_e;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q   <= '{instr: NOP_INSTR, pcplus4: '0};
            d_vld <= 1'b0;
        end else if (fq.flushQ) begin
            d_q   <= '{instr: NOP_INSTR, pcplus4: '0};
            d_vld <= 1'b0;
        end else if (d_load) begin
            if (pop) begin
                d_q   <= mem[rd_ptr];
                d_vld <= 1'b1;
            end else if (bypass) begin
                d_q   <= in_e;
                d_vld <= 1'b1;
            end else begin
                d_q   <= '{instr: NOP_INSTR, pcplus4: '0};
                d_vld <= 1'b0;
            end
        end
    end

    assign fq.instrD   = d_q.instr;
    assign fq.pcplus4D = d_q.pcplus4;
    assign fq.validD   = d_vld;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue: streaming, stall fill, push+pop, flush, async reset.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(32)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb [$];
    logic [31:0] e_instr = 32'h0;
    logic [31:0] e_pc    = 32'h0;
    logic        e_vld   = 1'b0;

    function automatic logic [31:0] w_of(input int i);
        return 32'h3000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] p_of(input int i);
        return 32'h0000_0100 + 32'(4 * i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".validD"},   32'(bus.validD), 32'(e_vld));
        check({tag, ".instrD"},   bus.instrD,      e_instr);
        check({tag, ".pcplus4D"}, bus.pcplus4D,    e_pc);
        check({tag, ".countQ"},   32'(bus.countQ), 32'(sb.size()));
        check({tag, ".readyF"},   32'(bus.readyF), 32'(sb.size() != DEPTH));
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl, output logic acc);
        logic [63:0] e;
        bus.validF   = v;
        bus.instrF   = ins;
        bus.pcplus4F = pc;
        bus.stallD   = st;
        bus.flushQ   = fl;
        acc = v & (sb.size() != DEPTH) & ~fl;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            e_instr = 32'h0;
            e_pc    = 32'h0;
            e_vld   = 1'b0;
        end else begin
            if (acc)
                sb.push_back({ins, pc});
            if (!st) begin
                if (sb.size() > 0) begin
                    e       = sb.pop_front();
                    e_instr = e[63:32];
                    e_pc    = e[31:0];
                    e_vld   = 1'b1;
                end else begin
                    e_instr = 32'h0;
                    e_pc    = 32'h0;
                    e_vld   = 1'b0;
                end
            end
        end
        check_all("step");
    endtask

    initial begin
        logic acc;
        int   idx;

        bus.validF   = 1'b0;
        bus.instrF   = 32'h0;
        bus.pcplus4F = 32'h0;
        bus.stallD   = 1'b0;
        bus.flushQ   = 1'b0;

        #2;
        check_all("reset");
        #10 reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("idle0");

        // Plain streaming: one-cycle latency, FIFO stays empty.
        step(1'b1, 32'h2001_0001, 32'h4, 1'b0, 1'b0, acc);
        check("stream1_instr", bus.instrD, 32'h2001_0001);
        step(1'b1, 32'h2002_0002, 32'h8, 1'b0, 1'b0, acc);
        step(1'b1, 32'h2003_0003, 32'hC, 1'b0, 1'b0, acc);
        check("stream3_pc", bus.pcplus4D, 32'hC);
        check("stream_cnt", 32'(bus.countQ), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        check("nop_vld", 32'(bus.validD), 32'd0);

        // Stall 6 cycles with 8 words streaming.
        step(1'b1, w_of(1), p_of(1), 1'b0, 1'b0, acc);
        idx = 2;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, w_of(idx), p_of(idx), 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_cnt",  32'(bus.countQ), 32'd4);
        check("stall_rdy",  32'(bus.readyF), 32'd0);
        check("stall_hold", bus.instrD, w_of(1));
        check("stall_idx",  32'(idx), 32'd6);
        for (int k = 0; k < 20 && idx <= 8; k++) begin
            step(1'b1, w_of(idx), p_of(idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        for (int k = 0; k < 6; k++)
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        // Simultaneous push and pop at count 2.
        step(1'b1, w_of(20), p_of(20), 1'b1, 1'b0, acc);
        step(1'b1, w_of(21), p_of(21), 1'b1, 1'b0, acc);
        step(1'b1, w_of(22), p_of(22), 1'b0, 1'b0, acc);
        check("pp_cnt",  32'(bus.countQ), 32'd2);
        check("pp_head", bus.instrD, w_of(20));
        for (int k = 0; k < 4; k++)
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        // Flush while full and stalled, with a valid word presented.
        for (int k = 0; k < 4; k++)
            step(1'b1, w_of(30 + k), p_of(30 + k), 1'b1, 1'b0, acc);
        check("fl_full", 32'(bus.countQ), 32'd4);
        step(1'b1, 32'hDEAD_BEEF, 32'h0000_0BEC, 1'b1, 1'b1, acc);
        check("fl_vld",   32'(bus.validD), 32'd0);
        check("fl_instr", bus.instrD, 32'h0);
        check("fl_cnt",   32'(bus.countQ), 32'd0);
        check("fl_rdy",   32'(bus.readyF), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        step(1'b1, w_of(40), p_of(40), 1'b0, 1'b0, acc);
        check("fl_next", bus.instrD, w_of(40));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        // Asynchronous reset mid-stream with count 3.
        for (int k = 0; k < 3; k++)
            step(1'b1, w_of(50 + k), p_of(50 + k), 1'b1, 1'b0, acc);
        check("pre_rst_cnt", 32'(bus.countQ), 32'd3);
        bus.validF = 1'b0;
        bus.stallD = 1'b0;
        #3 reset = 1'b0;
        #1;
        sb.delete();
        e_instr = 32'h0;
        e_pc    = 32'h0;
        e_vld   = 1'b0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_rel");
        step(1'b1, w_of(60), p_of(60), 1'b0, 1'b0, acc);
        step(1'b1, w_of(61), p_of(61), 1'b0, 1'b0, acc);
        check("restart", bus.instrD, w_of(61));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
